// File: rtl/hazard_ctrl_n_pkg.sv
// Shared constants for the hazard controller: stage bit positions and FSM states.
package hazard_ctrl_n_pkg;

  localparam int unsigned STG_IF     = 0;
  localparam int unsigned STG_IF_ID  = 1;
  localparam int unsigned STG_ID_EX  = 2;
  localparam int unsigned STG_EX_MEM = 3;
  localparam int unsigned STG_MEM_WB = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } hz_state_e;

  // Bits needed to hold the drain bubble count (value range 0..cycles).
  function automatic int unsigned dcnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_n_if.sv
// Datapath <-> hazard controller bundle: requests and halt in, stall/flush and statistics out.
interface hazard_ctrl_n_if #(
  parameter int unsigned NSTAGES = 5,
  parameter int unsigned NREQ    = 3,
  parameter int unsigned CNT_W   = 64
);
  logic [NREQ-1:0]    req_i;
  logic               halt_req_i;
  logic               halt_ack_o;
  logic               cnt_clr_i;
  logic [NSTAGES-1:0] stall_o;
  logic [NSTAGES-1:0] flush_o;
  logic [CNT_W-1:0]   nr_insts_o;
  logic [CNT_W-1:0]   nr_stall_o;
  logic [CNT_W-1:0]   nr_flush_o;

  modport master (
    output req_i, halt_req_i, cnt_clr_i,
    input  halt_ack_o, stall_o, flush_o, nr_insts_o, nr_stall_o, nr_flush_o
  );

  modport slave (
    input  req_i, halt_req_i, cnt_clr_i,
    output halt_ack_o, stall_o, flush_o, nr_insts_o, nr_stall_o, nr_flush_o
  );
endinterface

// File: rtl/hazard_ctrl_n_prio_sel.sv
// Fixed-priority hazard arbiter: the lowest-index active request alone selects its stall/flush masks.
module hazard_ctrl_n_prio_sel #(
  parameter int unsigned               NSTAGES     = 5,
  parameter int unsigned               NREQ        = 3,
  parameter logic [NREQ*NSTAGES-1:0]   STALL_MASKS = {5'b00011, 5'b00000, 5'b00111},
  parameter logic [NREQ*NSTAGES-1:0]   FLUSH_MASKS = {5'b00100, 5'b00010, 5'b01000}
) (
  input  logic [NREQ-1:0]    req_i,
  output logic [NSTAGES-1:0] stall_o,
  output logic [NSTAGES-1:0] flush_o
);

  logic [NREQ-1:0]              grant;
  logic [NREQ-1:0][NSTAGES-1:0] stall_terms;
  logic [NREQ-1:0][NSTAGES-1:0] flush_terms;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    if (gi == 0) begin : g_top
      assign grant[gi] = req_i[gi];
    end else begin : g_lower
      assign grant[gi] = req_i[gi] & ~(|req_i[gi-1:0]);
    end
    assign stall_terms[gi] = {NSTAGES{grant[gi]}} & STALL_MASKS[gi*NSTAGES +: NSTAGES];
    assign flush_terms[gi] = {NSTAGES{grant[gi]}} & FLUSH_MASKS[gi*NSTAGES +: NSTAGES];
  end

  // grant is one-hot (or zero), so OR-ing the gated terms is a pure mux.
  always_comb begin
    stall_o = '0;
    flush_o = '0;
    for (int r = 0; r < NREQ; r++) begin
      stall_o = stall_o | stall_terms[r];
      flush_o = flush_o | flush_terms[r];
    end
  end

endmodule

// File: rtl/hazard_ctrl_n.sv
// Pipeline hazard controller: prioritised stall/flush, debug halt/drain FSM and statistics counters.
module hazard_ctrl_n
  import hazard_ctrl_n_pkg::*;
#(
  parameter int unsigned             NSTAGES      = 5,
  parameter int unsigned             NREQ         = 3,
  parameter logic [NREQ*NSTAGES-1:0] STALL_MASKS  = {5'b00011, 5'b00000, 5'b00111},
  parameter logic [NREQ*NSTAGES-1:0] FLUSH_MASKS  = {5'b00100, 5'b00010, 5'b01000},
  parameter int unsigned             DRAIN_CYCLES = 3,
  parameter int unsigned             CNT_W        = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  hazard_ctrl_n_if.slave  bus
);

  localparam int unsigned       DCNT_W    = dcnt_width(DRAIN_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_INIT = DCNT_W'(DRAIN_CYCLES);

  logic [NSTAGES-1:0] hz_stall;
  logic [NSTAGES-1:0] hz_flush;
  logic [NSTAGES-1:0] stall_d;
  logic [NSTAGES-1:0] flush_d;
  hz_state_e          state_q;
  logic [DCNT_W-1:0]  dcnt_q;
  logic               halt_ack_q;
  logic               drain_step;
  logic [2:0]         cnt_inc;
  logic [2:0][CNT_W-1:0] cnt_val;

  hazard_ctrl_n_prio_sel #(
    .NSTAGES     (NSTAGES),
    .NREQ        (NREQ),
    .STALL_MASKS (STALL_MASKS),
    .FLUSH_MASKS (FLUSH_MASKS)
  ) u_prio_sel (
    .req_i   (bus.req_i),
    .stall_o (hz_stall),
    .flush_o (hz_flush)
  );

  // A bubble only counts toward the drain when nothing past IF is being held.
  assign drain_step = (hz_stall[NSTAGES-1:1] == '0);

  always_comb begin
    stall_d = '0;
    flush_d = '0;
    if (reset_n) begin
      case (state_q)
        ST_RUN: begin
          stall_d = hz_stall;
          flush_d = hz_flush;
        end
        ST_DRAIN: begin
          stall_d            = hz_stall;
          stall_d[STG_IF]    = 1'b1;
          flush_d            = hz_flush;
          flush_d[STG_IF_ID] = 1'b1;
        end
        ST_HALTED: stall_d = '1;
        default: begin
          stall_d = '0;
          flush_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      dcnt_q     <= '0;
      halt_ack_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.halt_req_i) begin
            state_q <= ST_DRAIN;
            dcnt_q  <= DCNT_INIT;
          end
        end
        ST_DRAIN: begin
          if (!bus.halt_req_i) begin
            state_q <= ST_RUN;
          end else if (drain_step) begin
            if (dcnt_q == DCNT_W'(1)) begin
              state_q    <= ST_HALTED;
              halt_ack_q <= 1'b1;
            end else begin
              dcnt_q <= dcnt_q - DCNT_W'(1);
            end
          end
        end
        ST_HALTED: begin
          if (!bus.halt_req_i) begin
            state_q    <= ST_RUN;
            halt_ack_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_RUN;
          halt_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_inc[0] = (state_q == ST_RUN) && (stall_d == '0) && (flush_d == '0);
  assign cnt_inc[1] = (stall_d != '0);
  assign cnt_inc[2] = (flush_d != '0);

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else if (bus.cnt_clr_i) begin
        cnt_q <= '0;
      end else if (cnt_inc[gi]) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
    assign cnt_val[gi] = cnt_q;
  end

  assign bus.stall_o    = stall_d;
  assign bus.flush_o    = flush_d;
  assign bus.halt_ack_o = halt_ack_q;
  assign bus.nr_insts_o = cnt_val[0];
  assign bus.nr_stall_o = cnt_val[1];
  assign bus.nr_flush_o = cnt_val[2];

endmodule

// File: tb/tb_hazard_ctrl_n.sv
// Scoreboard bench for hazard_ctrl_n: directed halt/drain scenarios followed by random traffic.
module tb_hazard_ctrl_n;

  localparam int NS = 5;
  localparam int NR = 3;
  localparam int DC = 3;
  localparam int CW = 64;

  localparam logic [4:0] SMASK [3] = '{5'b00111, 5'b00000, 5'b00011};
  localparam logic [4:0] FMASK [3] = '{5'b01000, 5'b00010, 5'b00100};

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  hazard_ctrl_n_if #(.NSTAGES(NS), .NREQ(NR), .CNT_W(CW)) bus ();

  hazard_ctrl_n #(
    .NSTAGES      (NS),
    .NREQ         (NR),
    .STALL_MASKS  ({5'b00011, 5'b00000, 5'b00111}),
    .FLUSH_MASKS  ({5'b00100, 5'b00010, 5'b01000}),
    .DRAIN_CYCLES (DC),
    .CNT_W        (CW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int              id;
    logic            rst;
    logic [2:0]      req;
    logic            halt;
    logic            clr;
    logic [4:0]      stall;
    logic [4:0]      flush;
    logic            ack;
    longint unsigned insts;
    longint unsigned stl;
    longint unsigned fls;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   txn_id      = 0;

  // Reference model: mode 0=running, 1=draining, 2=halted.
  int              m_mode  = 0;
  int              m_left  = 0;
  logic            m_ack   = 1'b0;
  longint unsigned m_insts = 0;
  longint unsigned m_stl   = 0;
  longint unsigned m_fls   = 0;

  task automatic model_step(input logic rst, input logic [2:0] req, input logic halt, input logic clr);
    exp_t       e;
    int         win;
    logic [4:0] hs;
    logic [4:0] hf;
    e.id   = txn_id;
    e.rst  = rst;
    e.req  = req;
    e.halt = halt;
    e.clr  = clr;
    txn_id++;
    if (!rst) begin
      m_mode = 0; m_left = 0; m_ack = 1'b0;
      m_insts = 0; m_stl = 0; m_fls = 0;
      e.stall = '0; e.flush = '0; e.ack = 1'b0;
      e.insts = 0; e.stl = 0; e.fls = 0;
      exp_q.push_back(e);
      return;
    end
    win = -1;
    for (int r = 0; r < NR; r++)
      if (req[r] && win < 0) win = r;
    hs = (win < 0) ? 5'b0 : SMASK[win];
    hf = (win < 0) ? 5'b0 : FMASK[win];
    if (m_mode == 0) begin
      e.stall = hs; e.flush = hf;
    end else if (m_mode == 1) begin
      e.stall = hs | 5'b00001; e.flush = hf | 5'b00010;
    end else begin
      e.stall = 5'b11111; e.flush = 5'b00000;
    end
    e.ack = m_ack; e.insts = m_insts; e.stl = m_stl; e.fls = m_fls;
    exp_q.push_back(e);

    if (clr) begin
      m_insts = 0; m_stl = 0; m_fls = 0;
    end else begin
      if (m_mode == 0 && e.stall == 0 && e.flush == 0) m_insts++;
      if (e.stall != 0) m_stl++;
      if (e.flush != 0) m_fls++;
    end
    case (m_mode)
      0: if (halt) begin m_mode = 1; m_left = DC; end
      1: begin
        if (!halt) m_mode = 0;
        else if ((hs & 5'b11110) == 0) begin
          if (m_left == 1) m_mode = 2;
          else m_left--;
        end
      end
      default: if (!halt) m_mode = 0;
    endcase
    m_ack = (m_mode == 2);
  endtask

  task automatic apply(input logic rst, input logic [2:0] req, input logic halt, input logic clr);
    @(posedge clock);
    #1;
    reset_n        = rst;
    bus.req_i      = req;
    bus.halt_req_i = halt;
    bus.cnt_clr_i  = clr;
    model_step(rst, req, halt, clr);
  endtask

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s txn=%0d got=%0h want=%0h", name, id, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      $display("txn %0d rst_n=%b req=%b halt=%b clr=%b stall=%b flush=%b ack=%b insts=%0d stl=%0d fls=%0d",
               e.id, e.rst, e.req, e.halt, e.clr, bus.stall_o, bus.flush_o, bus.halt_ack_o,
               bus.nr_insts_o, bus.nr_stall_o, bus.nr_flush_o);
      chk("stall",    e.id, 64'(bus.stall_o),    64'(e.stall));
      chk("flush",    e.id, 64'(bus.flush_o),    64'(e.flush));
      chk("halt_ack", e.id, 64'(bus.halt_ack_o), 64'(e.ack));
      chk("nr_insts", e.id, bus.nr_insts_o,      e.insts);
      chk("nr_stall", e.id, bus.nr_stall_o,      e.stl);
      chk("nr_flush", e.id, bus.nr_flush_o,      e.fls);
    end
  end

  initial begin
    logic [2:0] rq;
    logic       hl;
    bus.req_i      = '0;
    bus.halt_req_i = 1'b0;
    bus.cnt_clr_i  = 1'b0;
    repeat (2) apply(1'b0, 3'b000, 1'b0, 1'b0);
    repeat (10) apply(1'b1, 3'b000, 1'b0, 1'b0);
    apply(1'b1, 3'b001, 1'b0, 1'b0);
    apply(1'b1, 3'b110, 1'b0, 1'b0);
    // Clean halt: three bubbles then frozen.
    repeat (6) apply(1'b1, 3'b000, 1'b1, 1'b0);
    repeat (2) apply(1'b1, 3'b000, 1'b0, 1'b0);
    // Divide stall inside the drain delays the halt by two cycles.
    apply(1'b1, 3'b000, 1'b1, 1'b0);
    repeat (2) apply(1'b1, 3'b001, 1'b1, 1'b0);
    repeat (5) apply(1'b1, 3'b000, 1'b1, 1'b0);
    repeat (2) apply(1'b1, 3'b000, 1'b0, 1'b0);
    // Halt aborted mid-drain.
    repeat (2) apply(1'b1, 3'b000, 1'b1, 1'b0);
    repeat (2) apply(1'b1, 3'b000, 1'b0, 1'b0);
    // Reset pulse while halted.
    repeat (6) apply(1'b1, 3'b000, 1'b1, 1'b0);
    apply(1'b0, 3'b000, 1'b1, 1'b0);
    repeat (2) apply(1'b1, 3'b000, 1'b0, 1'b0);
    // Clear collides with an increment.
    repeat (3) apply(1'b1, 3'b001, 1'b0, 1'b0);
    apply(1'b1, 3'b000, 1'b0, 1'b1);
    repeat (2) apply(1'b1, 3'b000, 1'b0, 1'b0);

    hl = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) hl = ~hl;
      rq = ($urandom_range(1) == 0) ? 3'($urandom_range(7)) : 3'b000;
      apply(($urandom_range(399) != 0), rq, hl, ($urandom_range(31) == 0));
    end

    repeat (3) @(posedge clock);
    chk("queue_drained", -1, 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
